expr_result_checker: RTL and testbench
======================================

Name: expr_result_checker

Overview:
- Downstream consumer of the 90-bit packed result bus produced by the generated expression blocks.
- Accepts pairs of results over a valid/ready handshake: the design-under-test result and the golden-model result.
- Compares the pair field-by-field (18 fields), counts mismatches, latches the first failure, and compacts the DUT results into a 32-bit MISR signature.
- Provides the pass/fail and signature reporting for regression runs.

Parameters:
- Y_W, 90, packed result width.
- NFIELD, 18, number of result fields.
- CNT_W, 16, width of the vector and mismatch counters.
- SIG_SEED, 32'hFFFFFFFF, MISR reset/seed value.
- SIG_POLY, 32'h04C11DB7, MISR feedback polynomial.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; clears state and begins a run.
- num_vectors  in  CNT_W  vectors expected in the run; sampled on start.
- in_valid  in  1  result pair valid.
- in_ready  out  1  checker can accept a pair.
- y_dut  in  Y_W  DUT packed result.
- y_gold  in  Y_W  golden packed result.
- done  out  1  run complete; held until next start.
- pass  out  1  done with zero mismatches.
- mismatch_cnt  out  CNT_W  count of mismatching vectors; saturates at all-ones.
- first_fail_idx  out  CNT_W  vector index of the first mismatch.
- first_fail_field  out  5  lowest mismatching field index within that vector (0 = y0).
- signature  out  32  MISR over accepted y_dut.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Values under rst_n=0: state=IDLE; in_ready=0, done=0, pass=0, mismatch_cnt=0, first_fail_idx=0, first_fail_field=0, signature=SIG_SEED; pipeline valids cleared.
- Field layout, MSB first: y0 at [89:86], down to y17 at [5:0]. Field widths repeat 4,5,6,4,5,6 three times.
- A field mismatches on any bitwise difference. Signedness is irrelevant to the comparison.
- State machine:
  - IDLE --start--> RUN, or DONE directly if num_vectors==0 (pass=1, signature=SIG_SEED).
  - RUN: in_ready=1 while accepted < num_vectors. A pair is accepted on in_valid && in_ready. When the last pair is accepted -> DRAIN, and in_ready drops the next cycle.
  - DRAIN: waits until pipeline stages S1/S2 are empty -> DONE.
  - DONE --start--> RUN, with the same clear as from IDLE.
  - start is ignored in RUN and DRAIN.
- Pipeline:
  - S1 registers y_dut, y_gold and the vector index.
  - S2 computes the 18-bit mismatch mask, any_fail, the lowest set field (priority encoder), and fold = y_dut[31:0] ^ y_dut[63:32] ^ {6'b0, y_dut[89:64]}.
  - S3 updates counters and the signature.
  - done rises 3 cycles after the final accept.
- MISR update: sig <= {sig[30:0],1'b0} ^ (sig[31] ? SIG_POLY : 0) ^ fold, once per accepted vector, in acceptance order.
- first_fail_idx and first_fail_field are written only on the first failing vector of the run. Later failures increment mismatch_cnt only.
- Once mismatch_cnt reaches all-ones it holds; pass stays 0.
- in_valid while in_ready=0 has no effect. Inputs need not be held stable across cycles when in_ready=0.
- A start pulse clears counters, the first-fail registers and the signature, and drops done/pass in the same cycle it is sampled.
- If rst_n is asserted mid-run, everything returns to the reset values on that edge, and in-flight vectors are discarded.

Decomposition:
- Shared package expr_chk_pkg holds:
  - field offset/width constant arrays (FIELD_LSB[18], FIELD_W[18]);
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - SIG_POLY/SIG_SEED defaults;
  - a fold function.
- One sub-module, expr_field_cmp: combinational 18-field mismatch mask plus lowest-index priority encoder, instantiated in S2.

Test Plan:
- Reset, then start with num_vectors=4 and 4 identical pairs (y_dut=y_gold=90'h0) -> done 3 cycles after the 4th accept; pass=1; mismatch_cnt=0; signature equals the model value after 4 zero folds from SIG_SEED.
- num_vectors=3, and vector 1 differs only in bit 0 (field y17) -> mismatch_cnt=1, first_fail_idx=1, first_fail_field=17, pass=0.
- Vector 2 differs at bits [89] and [5] -> first_fail_field=0 (lowest index wins); a later failing vector does not change first_fail_*.
- Random in_valid gaps plus start asserted mid-RUN -> start is ignored; accepted count and signature match the model; in_ready=0 after the 4th accept.
- num_vectors=0 start -> DONE next cycle, pass=1, signature=32'hFFFFFFFF, in_ready never asserted.
- rst_n=0 during RUN after 2 accepts -> all outputs at reset values next cycle; a new start with 1 matching vector gives pass=1.

Source files
------------

// File: rtl/expr_chk_pkg.sv
// Shared constants, state encoding and fold helper for the expression result checker.
package expr_chk_pkg;

    localparam int RES_W      = 90;
    localparam int NUM_FIELDS = 18;

    localparam logic [31:0] DEF_SIG_SEED = 32'hFFFFFFFF;
    localparam logic [31:0] DEF_SIG_POLY = 32'h04C11DB7;

    // y0 sits at the MSB end; widths cycle 4,5,6.
    localparam int FIELD_LSB [NUM_FIELDS] = '{86, 81, 75, 71, 66, 60, 56, 51, 45,
                                              41, 36, 30, 26, 21, 15, 11,  6,  0};
    localparam int FIELD_W   [NUM_FIELDS] = '{ 4,  5,  6,  4,  5,  6,  4,  5,  6,
                                               4,  5,  6,  4,  5,  6,  4,  5,  6};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [31:0] fold(input logic [RES_W-1:0] y);
        return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    endfunction

endpackage

// File: rtl/expr_field_cmp.sv
// Per-field mismatch mask over a packed result pair plus lowest-index priority encoder.
module expr_field_cmp
    import expr_chk_pkg::*;
(
    input  logic [RES_W-1:0]      a,
    input  logic [RES_W-1:0]      b,
    output logic [NUM_FIELDS-1:0] mask,
    output logic [4:0]            first_field
);

    logic [RES_W-1:0] diff;
    assign diff = a ^ b;

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
        localparam logic [RES_W-1:0] FMASK =
            ((RES_W'(1) << FIELD_W[i]) - RES_W'(1)) << FIELD_LSB[i];
        assign mask[i] = |(diff & FMASK);
    end

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        first_field = '0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--)
            if (mask[i]) first_field = 5'(i);
    end

endmodule

// File: rtl/expr_result_checker.sv
// Compares DUT/golden result pairs through a 3-stage pipeline; reports mismatches and a MISR signature.
module expr_result_checker
    import expr_chk_pkg::*;
#(
    parameter int          Y_W      = RES_W,
    parameter int          NFIELD   = NUM_FIELDS,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] SIG_SEED = DEF_SIG_SEED,
    parameter logic [31:0] SIG_POLY = DEF_SIG_POLY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   y_dut,
    input  logic [Y_W-1:0]   y_gold,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [4:0]       first_fail_field,
    output logic [31:0]      signature
);

    localparam int STAGES = 2;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  nvec_q, acc_cnt;
    logic              accept, last_accept, clr;
    logic [STAGES:1]   vld_pipe;
    logic [Y_W-1:0]    s1_dut, s1_gold;
    logic [CNT_W-1:0]  s1_idx, s2_idx;
    logic [NFIELD-1:0] cmp_mask;
    logic [4:0]        cmp_field, s2_field;
    logic              s2_fail;
    logic [31:0]       s2_fold, sig;

    assign in_ready    = (state == RUN) && (acc_cnt < nvec_q);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (acc_cnt == nvec_q - CNT_W'(1));
    assign clr         = start && (state == IDLE || state == DONE);

    assign done      = (state == DONE);
    assign pass      = done && (mismatch_cnt == '0);
    assign signature = sig;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (num_vectors == '0) ? DONE : RUN;
            RUN:        if (last_accept) state_nxt = DRAIN;
            DRAIN:      if (vld_pipe == '0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    expr_field_cmp u_cmp (
        .a           (s1_dut),
        .b           (s1_gold),
        .mask        (cmp_mask),
        .first_field (cmp_field)
    );

    // Datapath stages carry no reset; vld_pipe qualifies every use.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_dut  <= y_dut;
            s1_gold <= y_gold;
            s1_idx  <= acc_cnt;
        end
        if (vld_pipe[1]) begin
            s2_fail  <= |cmp_mask;
            s2_field <= cmp_field;
            s2_idx   <= s1_idx;
            s2_fold  <= fold(s1_dut);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            nvec_q           <= '0;
            acc_cnt          <= '0;
            vld_pipe         <= '0;
            mismatch_cnt     <= '0;
            first_fail_idx   <= '0;
            first_fail_field <= '0;
            sig              <= SIG_SEED;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (clr) begin
                nvec_q           <= num_vectors;
                acc_cnt          <= '0;
                mismatch_cnt     <= '0;
                first_fail_idx   <= '0;
                first_fail_field <= '0;
                sig              <= SIG_SEED;
            end else begin
                if (accept) acc_cnt <= acc_cnt + 1'b1;
                if (vld_pipe[STAGES]) begin
                    if (s2_fail) begin
                        // A zero count means no earlier failure this run (the count never wraps).
                        if (mismatch_cnt == '0) begin
                            first_fail_idx   <= s2_idx;
                            first_fail_field <= s2_field;
                        end
                        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
                    end
                    sig <= {sig[30:0], 1'b0} ^ (sig[31] ? SIG_POLY : 32'h0) ^ s2_fold;
                end
            end
        end
    end

endmodule

// File: tb/tb_expr_result_checker.sv
// Randomized self-checking bench for expr_result_checker against a queue-based reference model.
module tb_expr_result_checker;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n, start, in_valid, in_ready, done, pass;
    logic [CNT_W-1:0] num_vectors, mismatch_cnt, first_fail_idx;
    logic [89:0]      y_dut, y_gold;
    logic [4:0]       first_fail_field;
    logic [31:0]      signature;

    int checks = 0;
    int errors = 0;

    logic [89:0] mq_dut[$];
    logic [89:0] mq_gold[$];

    always #5 clk = ~clk;

    expr_result_checker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .num_vectors      (num_vectors),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .y_dut            (y_dut),
        .y_gold           (y_gold),
        .done             (done),
        .pass             (pass),
        .mismatch_cnt     (mismatch_cnt),
        .first_fail_idx   (first_fail_idx),
        .first_fail_field (first_fail_field),
        .signature        (signature)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Walk fields from the MSB end; widths cycle 4,5,6.
    function automatic int ref_first_field(input logic [89:0] d, input logic [89:0] g);
        int pos = 89;
        for (int f = 0; f < 18; f++) begin
            int w = 4 + (f % 3);
            for (int b = 0; b < w; b++)
                if (d[pos-b] != g[pos-b]) return f;
            pos -= w;
        end
        return -1;
    endfunction

    function automatic logic [31:0] ref_sig();
        logic [31:0] s = 32'hFFFFFFFF;
        foreach (mq_dut[i]) begin
            logic [89:0] d = mq_dut[i];
            logic [31:0] f = d[31:0] ^ d[63:32] ^ {6'b0, d[89:64]};
            s = (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
        end
        return s;
    endfunction

    task automatic check_results(input string tag);
        int cnt = 0;
        int ffi = 0;
        int fff = 0;
        bit seen = 0;
        for (int i = 0; i < mq_dut.size(); i++) begin
            int f = ref_first_field(mq_dut[i], mq_gold[i]);
            if (f >= 0) begin
                if (!seen) begin seen = 1; ffi = i; fff = f; end
                if (cnt < 65535) cnt++;
            end
        end
        chk({tag, ".pass"},  64'(pass), 64'(cnt == 0));
        chk({tag, ".mcnt"},  64'(mismatch_cnt), 64'(cnt));
        chk({tag, ".ffidx"}, 64'(first_fail_idx), 64'(ffi));
        chk({tag, ".ffld"},  64'(first_fail_field), 64'(fff));
        chk({tag, ".sig"},   64'(signature), 64'(ref_sig()));
    endtask

    task automatic gen(input int mode, input int idx, output logic [89:0] d, output logic [89:0] g);
        logic [95:0] r = {$urandom, $urandom, $urandom};
        int bitpos;
        d = r[89:0];
        g = d;
        case (mode)
            0: begin d = '0; g = '0; end
            1: if (idx == 1) g[0] = ~d[0];
            2: begin
                if (idx == 2) begin g[89] = ~d[89]; g[5] = ~d[5]; end
                if (idx == 3) g[50] = ~d[50];
            end
            3: if ($urandom_range(0, 2) == 0) begin
                bitpos = $urandom_range(0, 89);
                g[bitpos] = ~g[bitpos];
            end
            default: ;
        endcase
    endtask

    // Starts a run, feeds nv pairs, then checks drain timing and final results.
    task automatic run(input string tag, input int nv, input int mode, input bit gaps, input bit start_mid);
        int acc = 0;
        int cyc = 0;
        bit sent = 0;
        bit fire;
        mq_dut.delete();
        mq_gold.delete();
        @(negedge clk); start = 1'b1; num_vectors = CNT_W'(nv);
        @(negedge clk); start = 1'b0;
        while (acc < nv && cyc < 200) begin
            logic [89:0] d, g;
            gen(mode, acc, d, g);
            y_dut    = d;
            y_gold   = g;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (start_mid && acc == 2 && !sent) begin
                sent = 1; start = 1'b1; num_vectors = 16'd9;
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) begin mq_dut.push_back(d); mq_gold.push_back(g); acc++; end
            cyc++;
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
        end
        chk({tag, ".accepted"}, 64'(acc), 64'(nv));
        chk({tag, ".ready_drop"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, ".done_early"}, 64'(done), 64'd0);
        @(negedge clk);
        chk({tag, ".done_lat3"}, 64'(done), 64'd1);
        check_results(tag);
    endtask

    initial begin
        int acc, cyc;
        bit fire;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        num_vectors = '0; y_dut = '0; y_gold = '0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.pass", 64'(pass), 64'd0);
        chk("rst.mcnt", 64'(mismatch_cnt), 64'd0);
        chk("rst.ffidx", 64'(first_fail_idx), 64'd0);
        chk("rst.ffld", 64'(first_fail_field), 64'd0);
        chk("rst.sig", 64'(signature), 64'hFFFFFFFF);
        rst_n = 1'b1;

        run("zeros", 4, 0, 1'b0, 1'b0);
        chk("zeros.pass_const", 64'(pass), 64'd1);

        run("bit0", 3, 1, 1'b0, 1'b0);
        chk("bit0.mcnt_const", 64'(mismatch_cnt), 64'd1);
        chk("bit0.ffidx_const", 64'(first_fail_idx), 64'd1);
        chk("bit0.ffld_const", 64'(first_fail_field), 64'd17);

        run("lowfld", 4, 2, 1'b0, 1'b0);
        chk("lowfld.mcnt_const", 64'(mismatch_cnt), 64'd2);
        chk("lowfld.ffidx_const", 64'(first_fail_idx), 64'd2);
        chk("lowfld.ffld_const", 64'(first_fail_field), 64'd0);

        run("gaps_start", 4, 3, 1'b1, 1'b1);

        // Zero-length run: straight to DONE with the seed signature.
        @(negedge clk); start = 1'b1; num_vectors = '0;
        @(negedge clk); start = 1'b0;
        chk("nv0.done", 64'(done), 64'd1);
        chk("nv0.pass", 64'(pass), 64'd1);
        chk("nv0.sig", 64'(signature), 64'hFFFFFFFF);
        chk("nv0.in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("nv0.in_ready2", 64'(in_ready), 64'd0);

        // Reset after two failing accepts discards the in-flight vectors.
        @(negedge clk); start = 1'b1; num_vectors = 16'd5;
        @(negedge clk); start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 2 && cyc < 50) begin
            in_valid = 1'b1;
            y_dut    = {$urandom, $urandom, $urandom};
            y_gold   = y_dut ^ 90'h1;
            fire     = in_valid && in_ready;
            @(posedge clk);
            if (fire) acc++;
            cyc++;
            @(negedge clk);
        end
        chk("mrst.accepted", 64'(acc), 64'd2);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("mrst.in_ready", 64'(in_ready), 64'd0);
        chk("mrst.done", 64'(done), 64'd0);
        chk("mrst.mcnt", 64'(mismatch_cnt), 64'd0);
        chk("mrst.ffidx", 64'(first_fail_idx), 64'd0);
        chk("mrst.sig", 64'(signature), 64'hFFFFFFFF);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst.mcnt_after", 64'(mismatch_cnt), 64'd0);
        chk("mrst.sig_after", 64'(signature), 64'hFFFFFFFF);
        run("recover", 1, 4, 1'b0, 1'b0);
        chk("recover.pass_const", 64'(pass), 64'd1);

        for (int k = 0; k < 4; k++)
            run($sformatf("rand%0d", k), $urandom_range(5, 12), 3, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
